cache_controller: RTL and testbench



---
 rtl/cache_controller_if.sv | 34 +++
 rtl/cache_controller.sv | 134 +++++++++++++
 tb/tb_cache_controller.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/cache_controller_if.sv
// Request/response bundle between the cache controller and its environment.
// The CPU request port and the block-wide memory port travel together.
//   slave  : the cache controller (consumes CPU requests, issues memory requests)
//   master : the environment (CPU driver and main-memory model)
// CPU side   : cpu_req_addr/datain/rw/valid in, cpu_req_dataout/cache_ready out
// Memory side: mem_req_addr/dataout/rw/valid out, mem_req_datain/ready in
interface cache_controller_if;
  logic [31:0]  cpu_req_addr;
  logic [31:0]  cpu_req_datain;
  logic [31:0]  cpu_req_dataout;
  logic         cpu_req_rw;
  logic         cpu_req_valid;
  logic         cache_ready;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_datain;
  logic [127:0] mem_req_dataout;
  logic         mem_req_rw;
  logic         mem_req_valid;
  logic         mem_req_ready;

  modport slave (
    input  cpu_req_addr, cpu_req_datain, cpu_req_rw, cpu_req_valid,
    input  mem_req_datain, mem_req_ready,
    output cpu_req_dataout, cache_ready,
    output mem_req_addr, mem_req_dataout, mem_req_rw, mem_req_valid
  );

  modport master (
    output cpu_req_addr, cpu_req_datain, cpu_req_rw, cpu_req_valid,
    output mem_req_datain, mem_req_ready,
    input  cpu_req_dataout, cache_ready,
    input  mem_req_addr, mem_req_dataout, mem_req_rw, mem_req_valid
  );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// 16 lines x 128-bit blocks; tag = addr[31:8], index = addr[7:4],
// word = addr[3:2]. A hit completes in one COMPARE_TAG cycle; a miss runs an
// optional write-back of the dirty victim followed by a block fill.
// Ports:
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset
//   bus        : CPU request port and memory port (cache_controller_if.slave)
//   state_mode : current FSM state (IDLE=0, COMPARE_TAG=1, ALLOCATE=2, WRITE_BACK=3)
module cache_controller (
  input  logic              clk,
  input  logic              rst_n,
  cache_controller_if.slave bus,
  output logic [1:0]        state_mode
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    COMPARE_TAG = 2'd1,
    ALLOCATE    = 2'd2,
    WRITE_BACK  = 2'd3
  } state_t;

  state_t       state;

  logic [15:0]  valid_q;
  logic [15:0]  dirty_q;
  logic [23:0]  tag_q  [16];
  logic [127:0] data_q [16];

  // Request latched in IDLE; CPU inputs are ignored for the rest of the transaction.
  logic [23:0]  req_tag;
  logic [3:0]   req_index;
  logic [1:0]   req_word;
  logic [31:0]  req_data;
  logic         req_rw;

  logic [23:0]  line_tag;
  logic [127:0] line_data;
  logic         hit;
  logic [31:0]  sel_word;

  always_comb begin
    line_tag  = tag_q[req_index];
    line_data = data_q[req_index];
    hit       = valid_q[req_index] && (line_tag == req_tag);
    sel_word  = line_data[{req_word, 5'b0} +: 32];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      valid_q   <= '0;
      dirty_q   <= '0;
      req_tag   <= '0;
      req_index <= '0;
      req_word  <= '0;
      req_data  <= '0;
      req_rw    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.cpu_req_valid) begin
            req_tag   <= bus.cpu_req_addr[31:8];
            req_index <= bus.cpu_req_addr[7:4];
            req_word  <= bus.cpu_req_addr[3:2];
            req_data  <= bus.cpu_req_datain;
            req_rw    <= bus.cpu_req_rw;
            state     <= COMPARE_TAG;
          end
        end
        COMPARE_TAG: begin
          if (hit) begin
            if (req_rw) begin
              data_q[req_index][{req_word, 5'b0} +: 32] <= req_data;
              dirty_q[req_index] <= 1'b1;
            end
            state <= IDLE;
          end else if (valid_q[req_index] && dirty_q[req_index]) begin
            state <= WRITE_BACK;
          end else begin
            state <= ALLOCATE;
          end
        end
        WRITE_BACK: begin
          if (bus.mem_req_ready) state <= ALLOCATE;
        end
        ALLOCATE: begin
          // Fill then re-compare: the second COMPARE_TAG hits and completes
          // the request, merging the write word for a write miss.
          if (bus.mem_req_ready) begin
            data_q[req_index]  <= bus.mem_req_datain;
            tag_q[req_index]   <= req_tag;
            valid_q[req_index] <= 1'b1;
            dirty_q[req_index] <= 1'b0;
            state              <= COMPARE_TAG;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.cache_ready     = 1'b0;
    bus.cpu_req_dataout = '0;
    bus.mem_req_valid   = 1'b0;
    bus.mem_req_rw      = 1'b0;
    bus.mem_req_addr    = '0;
    bus.mem_req_dataout = '0;
    unique case (state)
      COMPARE_TAG: begin
        if (hit) begin
          bus.cache_ready     = 1'b1;
          bus.cpu_req_dataout = sel_word;
        end
      end
      WRITE_BACK: begin
        bus.mem_req_valid   = 1'b1;
        bus.mem_req_rw      = 1'b1;
        bus.mem_req_addr    = {line_tag, req_index, 4'b0};
        bus.mem_req_dataout = line_data;
      end
      ALLOCATE: begin
        bus.mem_req_valid   = 1'b1;
        bus.mem_req_addr    = {req_tag, req_index, 4'b0};
      end
      default: ;
    endcase
  end

  assign state_mode = state;

endmodule

// File: tb/tb_cache_controller.sv
// Directed testbench for cache_controller: reset, cold read fill, read hit,
// write hit followed by dirty eviction, write miss merge, and reset mid-fill.
module tb_cache_controller;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_mode;

  cache_controller_if bus ();

  cache_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .state_mode (state_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [127:0] mem_blk [logic [31:0]];

  // Per-transaction observations collected by run_req.
  logic [31:0]  seq_pk;
  logic         done;
  int unsigned  rdy_cnt;
  int unsigned  rdy_at;
  logic [31:0]  rd_data;
  int unsigned  mem_act;
  logic         wb_seen;
  logic [31:0]  wb_addr;
  logic [127:0] wb_data;
  logic         al_seen;
  logic [31:0]  al_addr;
  logic         unstable;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Issue one CPU request at the next edge and follow it back to IDLE,
  // answering memory requests after `lat` cycles in each memory state.
  task automatic run_req(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic w, input int unsigned lat);
    int unsigned wait_cnt;
    seq_pk = '0; done = 1'b0; rdy_cnt = 0; rdy_at = 99; rd_data = '0; mem_act = 0;
    wb_seen = 1'b0; wb_addr = '0; wb_data = '0; al_seen = 1'b0; al_addr = '0;
    unstable = 1'b0; wait_cnt = 0;
    bus.cpu_req_addr   = a;
    bus.cpu_req_datain = d;
    bus.cpu_req_rw     = w;
    bus.cpu_req_valid  = 1'b1;
    @(negedge clk);
    bus.cpu_req_valid  = 1'b0;
    bus.cpu_req_addr   = 32'hFFFF_FFFC;
    bus.cpu_req_datain = 32'h5A5A_5A5A;
    bus.cpu_req_rw     = ~w;
    for (int unsigned c = 0; c < 40; c++) begin
      bus.mem_req_ready  = 1'b0;
      bus.mem_req_datain = '0;
      seq_pk = {seq_pk[27:0], 2'b00, state_mode};
      if (state_mode == 2'd0) begin
        done = 1'b1;
        break;
      end
      if (bus.cache_ready) begin
        if (rdy_cnt == 0) rdy_at = c;
        rdy_cnt++;
        rd_data = bus.cpu_req_dataout;
      end
      if (bus.mem_req_valid) begin
        mem_act++;
        if (bus.mem_req_rw) begin
          if (!wb_seen) begin
            wb_seen = 1'b1; wb_addr = bus.mem_req_addr; wb_data = bus.mem_req_dataout;
          end else if (bus.mem_req_addr !== wb_addr || bus.mem_req_dataout !== wb_data) begin
            unstable = 1'b1;
          end
        end else begin
          if (!al_seen) begin
            al_seen = 1'b1; al_addr = bus.mem_req_addr;
          end else if (bus.mem_req_addr !== al_addr || bus.mem_req_dataout !== '0) begin
            unstable = 1'b1;
          end
        end
        wait_cnt++;
        if (wait_cnt == lat) begin
          wait_cnt = 0;
          bus.mem_req_ready = 1'b1;
          if (bus.mem_req_rw) mem_blk[bus.mem_req_addr] = bus.mem_req_dataout;
          else if (mem_blk.exists(bus.mem_req_addr)) bus.mem_req_datain = mem_blk[bus.mem_req_addr];
        end
      end
      @(negedge clk);
    end
    bus.mem_req_ready = 1'b0;
    check({tag, "_done"}, done, 1'b1);
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.cpu_req_addr   = '0;
    bus.cpu_req_datain = '0;
    bus.cpu_req_rw     = 1'b0;
    bus.cpu_req_valid  = 1'b0;
    bus.mem_req_datain = '0;
    bus.mem_req_ready  = 1'b0;

    mem_blk[32'h0000_0100] = 128'h44444444_33333333_22222222_11111111;
    mem_blk[32'h0000_1100] = 128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1;
    mem_blk[32'h0000_0200] = 128'h88888888_77777777_66666666_55555555;
    mem_blk[32'h0000_0300] = {4{32'h3030_3030}};
    mem_blk[32'h0000_0410] = {4{32'h4141_4141}};

    // Reset held for two edges.
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_state", state_mode, 2'd0);
    check("rst_ready", bus.cache_ready, 1'b0);
    check("rst_mvalid", bus.mem_req_valid, 1'b0);
    check("rst_dout", bus.cpu_req_dataout, 32'h0);
    rst_n = 1'b1;

    // Cold read miss, 3-cycle memory latency.
    run_req("cold", 32'h0000_0104, 32'h0, 1'b0, 3);
    check("cold_seq", seq_pk, 32'h0012_2210);
    check("cold_aladdr", al_addr, 32'h0000_0100);
    check("cold_nowb", wb_seen, 1'b0);
    check("cold_rdycnt", rdy_cnt, 1);
    check("cold_data", rd_data, 32'h2222_2222);
    check("cold_stable", unstable, 1'b0);
    check("idle_dout", bus.cpu_req_dataout, 32'h0);
    check("idle_maddr", bus.mem_req_addr, 32'h0);

    // Read hit.
    run_req("hit", 32'h0000_010C, 32'h0, 1'b0, 1);
    check("hit_seq", seq_pk, 32'h0000_0010);
    check("hit_rdyat", rdy_at, 0);
    check("hit_data", rd_data, 32'h4444_4444);
    check("hit_mem", mem_act, 0);

    // Write hit marks the line dirty.
    run_req("whit", 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 1);
    check("whit_seq", seq_pk, 32'h0000_0010);
    check("whit_rdycnt", rdy_cnt, 1);
    check("whit_mem", mem_act, 0);

    // Conflicting read evicts the dirty line, 2-cycle latency each way.
    run_req("evict", 32'h0000_1104, 32'h0, 1'b0, 2);
    check("evict_seq", seq_pk, 32'h0133_2210);
    check("evict_wbaddr", wb_addr, 32'h0000_0100);
    check("evict_wbdata", wb_data, 128'h44444444_33333333_22222222_DEADBEEF);
    check("evict_aladdr", al_addr, 32'h0000_1100);
    check("evict_data", rd_data, 32'hA2A2_A2A2);
    check("evict_stable", unstable, 1'b0);

    // Write miss on a clean line: fill then merge.
    run_req("wmiss", 32'h0000_0208, 32'hCAFE_F00D, 1'b1, 1);
    check("wmiss_seq", seq_pk, 32'h0000_1210);
    check("wmiss_aladdr", al_addr, 32'h0000_0200);
    check("wmiss_nowb", wb_seen, 1'b0);
    run_req("wmiss_rd", 32'h0000_0208, 32'h0, 1'b0, 1);
    check("wmiss_rd_data", rd_data, 32'hCAFE_F00D);
    check("wmiss_rd_mem", mem_act, 0);

    // Evicting it writes back the merged word.
    run_req("evict2", 32'h0000_0300, 32'h0, 1'b0, 1);
    check("evict2_seq", seq_pk, 32'h0001_3210);
    check("evict2_wbaddr", wb_addr, 32'h0000_0200);
    check("evict2_wbdata", wb_data, 128'h88888888_CAFEF00D_66666666_55555555);
    check("evict2_aladdr", al_addr, 32'h0000_0300);
    check("evict2_data", rd_data, 32'h3030_3030);

    // Reset in the middle of ALLOCATE, with ready offered on the reset edge.
    bus.cpu_req_addr  = 32'h0000_0414;
    bus.cpu_req_rw    = 1'b0;
    bus.cpu_req_valid = 1'b1;
    @(negedge clk);
    bus.cpu_req_valid = 1'b0;
    check("rma_cmp", state_mode, 2'd1);
    @(negedge clk);
    check("rma_alloc", state_mode, 2'd2);
    check("rma_mvalid", bus.mem_req_valid, 1'b1);
    rst_n              = 1'b0;
    bus.mem_req_ready  = 1'b1;
    bus.mem_req_datain = mem_blk[32'h0000_0410];
    @(negedge clk);
    rst_n              = 1'b1;
    bus.mem_req_ready  = 1'b0;
    bus.mem_req_datain = '0;
    check("rma_state", state_mode, 2'd0);
    check("rma_mvalid0", bus.mem_req_valid, 1'b0);
    run_req("rma_again", 32'h0000_0414, 32'h0, 1'b0, 1);
    check("rma_again_seq", seq_pk, 32'h0000_1210);
    check("rma_again_aladdr", al_addr, 32'h0000_0410);
    check("rma_again_data", rd_data, 32'h4141_4141);

    // Earlier lines were invalidated by that reset too.
    run_req("post_rst", 32'h0000_0300, 32'h0, 1'b0, 1);
    check("post_rst_seq", seq_pk, 32'h0000_1210);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
